// File: rtl/midi_parser.sv
// midi_parser: byte-level MIDI parser.
// It decodes Note On, Note Off and Program Change messages and supports running status.
// The output is monophonic with last-note priority.
// Optional build macro MIDI_CHANNEL_FILTER_EN:
//   - defined: only messages whose status channel equals CHANNEL are acted upon.
//   - undefined: omni mode, every channel is accepted.
module midi_parser #(
  parameter logic [3:0] CHANNEL         = 4'd0,
  parameter logic [6:0] DEFAULT_PROGRAM = 7'd0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic [6:0] NOTE_NUM,
  output logic [6:0] VELOCITY,
  output logic [6:0] PROGRAM,
  output logic       GATE,
  output logic       NOTE_STB,
  output logic       PROG_STB
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_D1 = 2'd1;
  localparam logic [1:0] S_WAIT_D2 = 2'd2;

  localparam logic [2:0] K_NONE     = 3'd0;
  localparam logic [2:0] K_NOTE_OFF = 3'd1;
  localparam logic [2:0] K_NOTE_ON  = 3'd2;
  localparam logic [2:0] K_PROG     = 3'd3;
  localparam logic [2:0] K_OTHER2   = 3'd4;
  localparam logic [2:0] K_OTHER1   = 3'd5;

  logic [1:0] state;
  logic [2:0] kind;
  logic       accept;
  logic [6:0] d1;

  logic       is_rt, is_sys, is_status, is_data;
  logic       two_byte, chan_ok, msg_done;
  logic [2:0] new_kind;
  logic [6:0] msg_d1, msg_d2;

`ifdef MIDI_CHANNEL_FILTER_EN
  assign chan_ok = (RX_DATA[3:0] == CHANNEL);
`else
  logic unused_chan;
  assign unused_chan = ^CHANNEL;
  assign chan_ok     = 1'b1;
`endif

  // Classify the incoming byte and find out whether it completes a message.
  always_comb begin
    is_rt     = (RX_DATA[7:3] == 5'b11111);
    is_sys    = (RX_DATA[7:3] == 5'b11110);
    is_status = RX_DATA[7] && (RX_DATA[7:4] != 4'hF);
    is_data   = !RX_DATA[7];
    two_byte  = (kind == K_NOTE_OFF) || (kind == K_NOTE_ON) || (kind == K_OTHER2);
    case (RX_DATA[7:4])
      4'h8:    new_kind = K_NOTE_OFF;
      4'h9:    new_kind = K_NOTE_ON;
      4'hC:    new_kind = K_PROG;
      4'hD:    new_kind = K_OTHER1;
      default: new_kind = K_OTHER2;
    endcase
    msg_d1   = RX_DATA[6:0];
    msg_d2   = RX_DATA[6:0];
    msg_done = 1'b0;
    if (RX_VALID && is_data) begin
      if (state == S_WAIT_D2) begin
        msg_done = 1'b1;
        msg_d1   = d1;
      end else if (state == S_WAIT_D1 && !two_byte) begin
        msg_done = 1'b1;
      end
    end
  end

  // Parser state, running status and message actions. Strobes default low every cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      kind     <= K_NONE;
      accept   <= 1'b0;
      d1       <= 7'd0;
      NOTE_NUM <= 7'd0;
      VELOCITY <= 7'd0;
      PROGRAM  <= DEFAULT_PROGRAM;
      GATE     <= 1'b0;
      NOTE_STB <= 1'b0;
      PROG_STB <= 1'b0;
    end else begin
      NOTE_STB <= 1'b0;
      PROG_STB <= 1'b0;
      if (RX_VALID && !is_rt) begin
        if (is_sys) begin
          state  <= S_IDLE;
          kind   <= K_NONE;
          accept <= 1'b0;
        end else if (is_status) begin
          state  <= S_WAIT_D1;
          kind   <= new_kind;
          accept <= chan_ok;
        end else if (state == S_WAIT_D1 && two_byte) begin
          d1    <= RX_DATA[6:0];
          state <= S_WAIT_D2;
        end else if (state == S_WAIT_D2) begin
          state <= S_WAIT_D1;
        end
      end
      // A completed, accepted message drives the outputs.
      if (msg_done && accept) begin
        case (kind)
          K_NOTE_ON, K_NOTE_OFF: begin
            if (kind == K_NOTE_ON && msg_d2 != 7'd0) begin
              NOTE_NUM <= msg_d1;
              VELOCITY <= msg_d2;
              GATE     <= 1'b1;
              NOTE_STB <= 1'b1;
            end else if (GATE && msg_d1 == NOTE_NUM) begin
              GATE <= 1'b0;
            end
          end
          K_PROG: begin
            PROGRAM  <= msg_d1;
            PROG_STB <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_parser.sv
// Self-checking bench for midi_parser: directed scenarios plus a random byte stream
// compared against a message-level reference model.
module tb_midi_parser;

  localparam logic [3:0] CH   = 4'd0;
  localparam logic [6:0] DPRG = 7'h11;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       RX_VALID = 1'b0;
  logic [6:0] NOTE_NUM, VELOCITY, PROGRAM;
  logic       GATE, NOTE_STB, PROG_STB;

  int n_cmp = 0;
  int n_bad = 0;

  midi_parser #(.CHANNEL(CH), .DEFAULT_PROGRAM(DPRG)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .NOTE_NUM(NOTE_NUM), .VELOCITY(VELOCITY), .PROGRAM(PROGRAM),
    .GATE(GATE), .NOTE_STB(NOTE_STB), .PROG_STB(PROG_STB)
  );

  always #5 CLK = ~CLK;

  // Observed strobe pulses, one count per high cycle.
  int obs_nstb = 0;
  int obs_pstb = 0;
  always @(negedge CLK) begin
    if (NOTE_STB === 1'b1) obs_nstb++;
    if (PROG_STB === 1'b1) obs_pstb++;
  end

  // Reference model: current running status byte (-1 = none) and the data bytes
  // collected for the message in progress.
  int         m_rs = -1;
  logic [6:0] m_q[$];
  logic [6:0] m_note = 7'd0, m_vel = 7'd0, m_prog = DPRG;
  logic       m_gate = 1'b0;
  int         m_nstb = 0;
  int         m_pstb = 0;

  function automatic bit m_accept(int rs);
`ifdef MIDI_CHANNEL_FILTER_EN
    return (rs % 16) == int'(CH);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_rs = -1; m_q.delete();
    m_note = 7'd0; m_vel = 7'd0; m_prog = DPRG; m_gate = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int hi, need;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin m_rs = -1; m_q.delete(); return; end
    if (b >= 8'h80) begin m_rs = int'(b); m_q.delete(); return; end
    if (m_rs < 0) return;
    m_q.push_back(b[6:0]);
    hi   = m_rs / 16;
    need = (hi == 12 || hi == 13) ? 1 : 2;
    if (m_q.size() < need) return;
    if (m_accept(m_rs)) begin
      if (hi == 9 && m_q[1] != 0) begin
        m_note = m_q[0]; m_vel = m_q[1]; m_gate = 1'b1; m_nstb++;
      end else if (hi == 8 || hi == 9) begin
        if (m_gate && m_q[0] == m_note) m_gate = 1'b0;
      end else if (hi == 12) begin
        m_prog = m_q[0]; m_pstb++;
      end
    end
    m_q.delete();
  endtask

  // Called at negedge+1; presents one byte for one cycle and returns at the next negedge+1.
  task automatic send(input logic [7:0] b);
    RX_DATA = b; RX_VALID = 1'b1;
    model_byte(b);
    @(negedge CLK); #1;
    RX_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(negedge CLK); #1;
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (NOTE_NUM !== 7'd0) begin n_bad++; $display("FAIL reset_note got %h want 00", NOTE_NUM); end
    n_cmp++; if (VELOCITY !== 7'd0) begin n_bad++; $display("FAIL reset_vel got %h want 00", VELOCITY); end
    n_cmp++; if (PROGRAM !== DPRG) begin n_bad++; $display("FAIL reset_prog got %h want %h", PROGRAM, DPRG); end
    n_cmp++; if ({GATE, NOTE_STB, PROG_STB} !== 3'b000) begin n_bad++; $display("FAIL reset_bits got %b want 000", {GATE, NOTE_STB, PROG_STB}); end
  endtask

  task automatic test_note_on_off();
    int s0;
    do_reset();
    s0 = obs_nstb;
    send(8'h90); send(8'h3C); send(8'h64);
    n_cmp++; if (NOTE_STB !== 1'b1) begin n_bad++; $display("FAIL note_stb_now got %b want 1", NOTE_STB); end
    n_cmp++; if ({NOTE_NUM, VELOCITY, GATE} !== {7'h3C, 7'h64, 1'b1}) begin n_bad++; $display("FAIL note_on got %h/%h/%b want 3c/64/1", NOTE_NUM, VELOCITY, GATE); end
    @(negedge CLK); #1;
    n_cmp++; if (obs_nstb - s0 !== 1) begin n_bad++; $display("FAIL note_stb_count got %0d want 1", obs_nstb - s0); end
    send(8'h80); send(8'h3C); send(8'h00);
    n_cmp++; if ({NOTE_NUM, VELOCITY, GATE} !== {7'h3C, 7'h64, 1'b0}) begin n_bad++; $display("FAIL note_off got %h/%h/%b want 3c/64/0", NOTE_NUM, VELOCITY, GATE); end
  endtask

  task automatic test_running_status();
    do_reset();
    send(8'h90); send(8'h40); send(8'h50); send(8'h43); send(8'h50);
    n_cmp++; if ({NOTE_NUM, NOTE_STB, GATE} !== {7'h43, 1'b1, 1'b1}) begin n_bad++; $display("FAIL rs_second got %h/%b/%b want 43/1/1", NOTE_NUM, NOTE_STB, GATE); end
    send(8'h40); send(8'h00);
    n_cmp++; if ({NOTE_NUM, GATE} !== {7'h43, 1'b1}) begin n_bad++; $display("FAIL rs_stale_off got %h/%b want 43/1", NOTE_NUM, GATE); end
    send(8'h43); send(8'h00);
    n_cmp++; if (GATE !== 1'b0) begin n_bad++; $display("FAIL rs_vel0_off got %b want 0", GATE); end
  endtask

  task automatic test_realtime_sysex();
    do_reset();
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    n_cmp++; if ({NOTE_NUM, VELOCITY, GATE} !== {7'h3C, 7'h64, 1'b1}) begin n_bad++; $display("FAIL rt_interleave got %h/%h/%b want 3c/64/1", NOTE_NUM, VELOCITY, GATE); end
    send(8'h90); send(8'h30); send(8'hF0); send(8'h64);
    send(8'h31); send(8'h22);
    n_cmp++; if ({NOTE_NUM, VELOCITY, GATE} !== {7'h3C, 7'h64, 1'b1}) begin n_bad++; $display("FAIL sysex_abort got %h/%h/%b want 3c/64/1", NOTE_NUM, VELOCITY, GATE); end
    send(8'h90); send(8'h30); send(8'h80); send(8'h3C); send(8'h00);
    n_cmp++; if ({NOTE_NUM, GATE} !== {7'h3C, 1'b0}) begin n_bad++; $display("FAIL status_abort got %h/%b want 3c/0", NOTE_NUM, GATE); end
  endtask

  task automatic test_back_to_back_prog();
    int s0;
    do_reset();
    s0 = obs_pstb;
    send(8'hC0); send(8'h05);
    n_cmp++; if ({PROGRAM, PROG_STB} !== {7'h05, 1'b1}) begin n_bad++; $display("FAIL prog_first got %h/%b want 05/1", PROGRAM, PROG_STB); end
    send(8'hC0); send(8'h07);
    n_cmp++; if ({PROGRAM, PROG_STB} !== {7'h07, 1'b1}) begin n_bad++; $display("FAIL prog_second got %h/%b want 07/1", PROGRAM, PROG_STB); end
    send(8'h09);
    n_cmp++; if (PROGRAM !== 7'h09) begin n_bad++; $display("FAIL prog_running got %h want 09", PROGRAM); end
    send(8'hB0); send(8'h07); send(8'h7F);
    @(negedge CLK); #1;
    n_cmp++; if (obs_pstb - s0 !== 3) begin n_bad++; $display("FAIL prog_stb_count got %0d want 3", obs_pstb - s0); end
    n_cmp++; if ({PROGRAM, GATE, NOTE_NUM} !== {7'h09, 1'b0, 7'h00}) begin n_bad++; $display("FAIL ctrl_change got %h/%b/%h want 09/0/00", PROGRAM, GATE, NOTE_NUM); end
  endtask

  task automatic test_channel();
    do_reset();
    send(8'h91); send(8'h30); send(8'h40);
`ifdef MIDI_CHANNEL_FILTER_EN
    n_cmp++; if ({GATE, NOTE_NUM} !== {1'b0, 7'h00}) begin n_bad++; $display("FAIL chan_other got %b/%h want 0/00", GATE, NOTE_NUM); end
`else
    n_cmp++; if ({GATE, NOTE_NUM} !== {1'b1, 7'h30}) begin n_bad++; $display("FAIL chan_omni got %b/%h want 1/30", GATE, NOTE_NUM); end
`endif
    send(8'h90); send(8'h30); send(8'h40);
    n_cmp++; if ({GATE, NOTE_NUM, VELOCITY} !== {1'b1, 7'h30, 7'h40}) begin n_bad++; $display("FAIL chan_match got %b/%h/%h want 1/30/40", GATE, NOTE_NUM, VELOCITY); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h64);
    n_cmp++; if ({NOTE_NUM, VELOCITY, PROGRAM, GATE} !== {7'h00, 7'h00, DPRG, 1'b0}) begin n_bad++; $display("FAIL reset_mid got %h/%h/%h/%b", NOTE_NUM, VELOCITY, PROGRAM, GATE); end
    // Reset and a valid byte in the same cycle: reset wins.
    send(8'h90); send(8'h3C);
    RST = 1'b1; RX_DATA = 8'h64; RX_VALID = 1'b1;
    @(negedge CLK); #1;
    RST = 1'b0; RX_VALID = 1'b0; model_reset();
    send(8'h64);
    n_cmp++; if ({NOTE_NUM, GATE, NOTE_STB} !== {7'h00, 1'b0, 1'b0}) begin n_bad++; $display("FAIL reset_priority got %h/%b/%b want 00/0/0", NOTE_NUM, GATE, NOTE_STB); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int         r, bad_here;
    do_reset();
    m_nstb = 0; m_pstb = 0;
    obs_nstb = 0; obs_pstb = 0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       b = 8'hF8 + 8'($urandom_range(0, 7));
      else if (r < 12) b = 8'hF0 + 8'($urandom_range(0, 7));
      else if (r < 35) b = {4'($urandom_range(8, 14)), 4'($urandom_range(0, 1))};
      else if (r < 47) b = 8'h00;
      else             b = 8'h3C + 8'($urandom_range(0, 3));
      send(b);
      if ($urandom_range(0, 3) == 0) begin @(negedge CLK); #1; end
      bad_here = 0;
      n_cmp++;
      if ({NOTE_NUM, VELOCITY, PROGRAM, GATE} !== {m_note, m_vel, m_prog, m_gate}) begin
        n_bad++; bad_here = 1;
        $display("FAIL rand_out[%0d] byte %h got %h/%h/%h/%b want %h/%h/%h/%b", i, b,
                 NOTE_NUM, VELOCITY, PROGRAM, GATE, m_note, m_vel, m_prog, m_gate);
      end
      n_cmp++;
      if (obs_nstb !== m_nstb || obs_pstb !== m_pstb) begin
        n_bad++; bad_here = 1;
        $display("FAIL rand_stb[%0d] got %0d/%0d want %0d/%0d", i, obs_nstb, obs_pstb, m_nstb, m_pstb);
      end
      if (bad_here != 0) break;
    end
  endtask

  initial begin
    @(negedge CLK); #1;
    test_reset();
    test_note_on_off();
    test_running_status();
    test_realtime_sysex();
    test_back_to_back_prog();
    test_channel();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/midi_parser.md
# midi_parser

Byte-level MIDI message parser that sits directly upstream of the NCO. It consumes bytes from the UART receiver and decodes Note On, Note Off and Program Change messages, with running-status support. It drives the NCO's note-number and program inputs, and provides a gate and a velocity for the following envelope/amplitude stage. It is monophonic with last-note priority.

## Interface
Parameters:
- CHANNEL, 4'd0: MIDI channel (0–15) accepted when channel filtering is compiled in.
- DEFAULT_PROGRAM, 7'd0: PROGRAM value after reset.

Ports:
- CLK  in  1  system clock (100 MHz); all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- RX_DATA  in  8  received byte; valid only when RX_VALID=1.
- RX_VALID  in  1  single-cycle strobe per received byte; back-to-back strobes on consecutive cycles are legal.
- NOTE_NUM  out  7  current note number; feeds the NCO note input.
- VELOCITY  out  7  velocity of the current note.
- PROGRAM  out  7  current program number; feeds the NCO program input.
- GATE  out  1  high while a note is held.
- NOTE_STB  out  1  one-cycle pulse when NOTE_NUM/VELOCITY are loaded by a Note On.
- PROG_STB  out  1  one-cycle pulse when PROGRAM is loaded.

## Operation
- State machine with states IDLE, WAIT_D1 and WAIT_D2.
  - IDLE: no running status.
  - WAIT_D1: expecting the first data byte.
  - WAIT_D2: expecting the second data byte.
- Registered running status: kind (NOTE_OFF, NOTE_ON, PROG, OTHER2, OTHER1, NONE) plus the accept flag.
- Data byte 1 is latched in a 7-bit register.
- Byte classes (evaluated only when RX_VALID=1):
  - 0xF8–0xFF (real-time): ignored completely. No change to state, running status or the data latch.
  - 0xF0–0xF7 (system common/SysEx): running status becomes NONE and the state goes to IDLE. Following data bytes are discarded.
  - 0x80–0xEF (channel status): loads running status. Upper nibble 8→NOTE_OFF, 9→NOTE_ON, C→PROG, A/B/E→OTHER2, D→OTHER1. State goes to WAIT_D1. A status byte arriving in WAIT_D2 aborts the partial message; no outputs change.
  - 0x00–0x7F (data):
    - IDLE: discarded.
    - WAIT_D1 with a two-byte kind: latch the byte, go to WAIT_D2.
    - WAIT_D1 with a one-byte kind: complete the message.
    - WAIT_D2: complete the message.
- After a completed message, return to WAIT_D1 with running status retained (running status).
- Message actions, performed only when the accept flag is set:
  - NOTE_ON with velocity > 0: NOTE_NUM←note, VELOCITY←vel, GATE←1, NOTE_STB pulse. A new note overrides a held one (last-note priority, no note stack).
  - NOTE_ON with velocity = 0: treated exactly as NOTE_OFF.
  - NOTE_OFF: if GATE=1 and note==NOTE_NUM, then GATE←0. Otherwise no effect. NOTE_NUM and VELOCITY hold their values after gate-off, so the NCO keeps its pitch for the release.
  - PROG: PROGRAM←data, PROG_STB pulse.
  - OTHER1/OTHER2: bytes are consumed, no output change.
- A message whose accept flag is clear is consumed byte-for-byte with no output change.

## Timing
- Reset values:
  - NOTE_NUM=0, VELOCITY=0, PROGRAM=DEFAULT_PROGRAM.
  - GATE=0, NOTE_STB=0, PROG_STB=0.
  - State IDLE, running status NONE, data latch 0.
- RST has priority over RX_VALID in the same cycle. Reset mid-message discards the partial message.
- Latency: outputs and strobes update on the clock edge that samples RX_VALID with the final data byte. They are visible in the following cycle.
- Strobes are high for exactly one cycle per completed accepted message.
- One byte is processed per RX_VALID; there is no back-pressure and no input buffering.
- All arithmetic is 7-bit compares only. The data byte's MSB is 0 by class, so no truncation occurs.

## Configuration
- MIDI_CHANNEL_FILTER_EN defined: the accept flag is set only when status[3:0]==CHANNEL. Messages on other channels are consumed but produce no output change.
- MIDI_CHANNEL_FILTER_EN undefined: omni mode. The accept flag is always 1 for channel status bytes, and CHANNEL is unused.

## Test plan
- Reset, then 0x90 0x3C 0x64: after the last byte, NOTE_NUM=0x3C, VELOCITY=0x64, GATE=1, NOTE_STB pulses once. Then 0x80 0x3C 0x00 → GATE=0, NOTE_NUM stays 0x3C.
- Running status 0x90 0x40 0x50 0x43 0x50 0x40 0x00: second note sets NOTE_NUM=0x43 with NOTE_STB. The following 0x40 0x00 (note-off for a non-current note) leaves GATE=1.
- 0x90 0x3C 0xF8 0x64 (clock byte interleaved): result is identical to the uninterrupted message. 0x90 0x3C 0xF0 0x64 → no output change, state IDLE.
- 0xC0 0x05, then 0xC0 0x07 on consecutive RX_VALID cycles: PROGRAM=0x05 then 0x07, with two PROG_STB pulses. 0xB0 0x07 0x7F → no output change.
- With MIDI_CHANNEL_FILTER_EN and CHANNEL=0: 0x91 0x30 0x40 → no change. 0x90 0x30 0x40 → GATE=1, NOTE_NUM=0x30. Without the macro, both messages are accepted.
- RST asserted between 0x90 0x3C and the velocity byte: the velocity byte is discarded in IDLE and all outputs hold their reset values.
